// File: rtl/midi_event_framer.sv
// Frames a raw MIDI byte stream into channel-voice events (status + up to two data bytes)
// and queues them on a valid/ack interface for the voice-allocation logic.
module midi_event_framer #(
    parameter int unsigned FIFO_DEPTH          = 4,
    parameter bit          NOTE_ON_ZERO_TO_OFF = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    input  logic                          midi_event_ack,
    output logic                          midi_event_valid,
    output logic [7:0]                    midi_command,
    output logic [6:0]                    midi_parameter_1,
    output logic [6:0]                    midi_parameter_2,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [7:0]  running_status;
    logic        data_count;
    logic [6:0]  p1_hold;
    logic        sysex;

    logic        is_data;
    logic        accept_data;
    logic        two_param;
    logic        complete;
    logic [7:0]  evt_command;
    logic [6:0]  evt_p1;
    logic [6:0]  evt_p2;

    logic [21:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic        pop;
    logic        full;
    logic        wr_en;
    logic        drop;
    logic [21:0] head;

    assign is_data     = ~byte_data[7];
    assign accept_data = ~sysex && (running_status != 8'h00);
    assign two_param   = ~((running_status[7:4] == 4'hC) || (running_status[7:4] == 4'hD));
    assign complete    = byte_valid && is_data && accept_data && (data_count || ~two_param);

    always_comb begin
        evt_command = running_status;
        evt_p1      = byte_data[6:0];
        evt_p2      = '0;
        if (data_count) begin
            evt_p1 = p1_hold;
            evt_p2 = byte_data[6:0];
        end
        if (NOTE_ON_ZERO_TO_OFF && (running_status[7:4] == 4'h9) && (evt_p2 == 7'h00)) begin
            evt_command = {4'h8, running_status[3:0]};
        end
    end

    // Real-time bytes (F8-FF) fall through every branch and leave the parser untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_status <= '0;
            data_count     <= 1'b0;
            p1_hold        <= '0;
            sysex          <= 1'b0;
        end else if (byte_valid) begin
            if (!is_data) begin
                if (byte_data < 8'hF0) begin
                    running_status <= byte_data;
                    data_count     <= 1'b0;
                    sysex          <= 1'b0;
                end else if (byte_data == 8'hF0) begin
                    running_status <= '0;
                    data_count     <= 1'b0;
                    sysex          <= 1'b1;
                end else if (byte_data < 8'hF8) begin
                    running_status <= '0;
                    data_count     <= 1'b0;
                    sysex          <= 1'b0;
                end
            end else if (accept_data) begin
                if (data_count) begin
                    data_count <= 1'b0;
                end else if (two_param) begin
                    p1_hold    <= byte_data[6:0];
                    data_count <= 1'b1;
                end
            end
        end
    end

    assign pop   = midi_event_valid && midi_event_ack;
    assign full  = (fifo_level == LW'(FIFO_DEPTH));
    assign wr_en = complete && (~full || pop);
    assign drop  = complete && ~wr_en;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {evt_command, evt_p1, evt_p2};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= drop;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !wr_en) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    // Head fields are masked while empty so reset shows zeros without resetting the storage.
    assign midi_event_valid = (fifo_level != '0);
    assign head             = mem[rd_ptr];
    assign midi_command     = midi_event_valid ? head[21:14] : '0;
    assign midi_parameter_1 = midi_event_valid ? head[13:7]  : '0;
    assign midi_parameter_2 = midi_event_valid ? head[6:0]   : '0;

endmodule

// File: doc/midi_event_framer.md
# midi_event_framer

Frames the raw byte stream from the MIDI UART receiver into complete channel-voice events (command plus up to two parameters) and queues them for the voice-allocation logic in the MIDI player. It sits directly upstream of the player: bytes arrive as single-cycle strobes, and events leave on the player's valid/ack handshake. The block handles running status, system-common/SysEx skipping, real-time byte transparency and note-on-velocity-0 conversion, and buffers events in a small FIFO.

## Interface
- `FIFO_DEPTH`, 4: event queue depth; power of two, ≥2.
- `NOTE_ON_ZERO_TO_OFF`, 1: when 1, a note-on (0x9n) with velocity 0 is emitted as note-off 0x8n, p2=0.

- `clk` in 1: system clock (16 MHz domain); all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `byte_valid` in 1: single-cycle strobe; `byte_data` is valid in this cycle.
- `byte_data` in 8: received MIDI byte.
- `midi_event_ack` in 1: consumer acknowledge; pops the head entry when sampled high together with `midi_event_valid`.
- `midi_event_valid` out 1: the FIFO is non-empty; the head event is presented.
- `midi_command` out 8: head status byte.
- `midi_parameter_1` out 7: head data byte 1.
- `midi_parameter_2` out 7: head data byte 2; 0 for one-parameter commands.
- `overflow` out 1: one-cycle pulse when a completed event is dropped because the FIFO is full.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of queued events.

## Operation
- Parser state: `running_status` (8b, 0 = none), `data_count` (0/1), `p1_hold` (7b), `sysex` flag.
- Expected length is derived from `running_status[7:4]`: 8,9,A,B,E → 2 data bytes; C,D → 1.
- Byte classes, evaluated only when `byte_valid` is high:
  - 0xF8–0xFF (real-time): ignored entirely; no parser state changes. A SysEx in progress continues.
  - 0x80–0xEF: `running_status` ← byte, `data_count` ← 0, `sysex` ← 0.
  - 0xF0: `running_status` ← 0, `sysex` ← 1.
  - 0xF1–0xF7: `running_status` ← 0, `sysex` ← 0. The block emits no system-common events.
  - 0x00–0x7F with `sysex`=1 or `running_status`=0: discarded.
  - 0x00–0x7F with `data_count`=0 and a one-parameter command: the event {status, byte, 0} is completed.
  - 0x00–0x7F with `data_count`=0 and a two-parameter command: `p1_hold` ← byte, `data_count` ← 1.
  - 0x00–0x7F with `data_count`=1: the event {status, p1_hold, byte} is completed and `data_count` ← 0. Running status is retained, so following data pairs form new events.
- Conversion: if `NOTE_ON_ZERO_TO_OFF`=1 and a completed event is 0x9n with p2=0, the block writes {0x8n, p1, 0}.
- FIFO write of a completed event:
  - If not full, or if a pop occurs in the same cycle: the event is written.
  - Otherwise: the event is dropped, `overflow` pulses, and parser state still advances.
- Pop: `midi_event_valid` && `midi_event_ack` removes the head. `midi_event_ack` while the FIFO is empty is ignored.
- Read and write pointers wrap modulo `FIFO_DEPTH`. `fifo_level` is always in 0..FIFO_DEPTH.

## Timing
- Reset (async assert, sync-clean deassert):
  - `midi_event_valid`=0, `midi_command`=0, both parameters=0, `overflow`=0, `fifo_level`=0.
  - Parser is cleared: `running_status`=0, `data_count`=0, `sysex`=0.
  - Reset mid-event discards the partial event and all queued events.
- Latency: for a completing byte strobed in cycle k, the FIFO write happens at the end of cycle k.
  - With the FIFO previously empty, `midi_event_valid`=1 and the head fields are valid from cycle k+1.
- Head outputs are stable while `midi_event_valid`=1 and no pop occurs.
- After a pop at the end of cycle j, cycle j+1 shows the next entry, or `midi_event_valid`=0 if the FIFO emptied.
- Consumer pattern: ack is a one-cycle pulse asserted the cycle after valid is seen. A back-to-back queue therefore drains at one event per 2 cycles.
- Simultaneous write and pop: `fifo_level` is unchanged.
  - Simultaneous write and pop when empty cannot occur, because pop requires valid.
- `overflow` is asserted in cycle k+1 for a drop caused by the byte strobed in cycle k.
- Back-to-back `byte_valid` strobes on consecutive cycles must be accepted.

## Test plan
- **Note-on:** bytes 0x92,0x3C,0x64 → one event {0x92,0x3C,0x64}, valid one cycle after the 3rd strobe; ack pulse → `fifo_level` 1→0, valid drops the next cycle.
- **Running status with conversion:** 0x90,0x40,0x50,0x40,0x00 → events {0x90,0x40,0x50} then {0x80,0x40,0x00}. With `NOTE_ON_ZERO_TO_OFF`=0 the second event is {0x90,0x40,0x00}.
- **Real-time interleave and one-parameter command:** 0xB0,0xF8,0x01,0xFE,0x7F → {0xB0,0x01,0x7F}. Then 0xC3,0x05 → {0xC3,0x05,0x00}.
- **SysEx and orphan data:** 0xF0,0x7E,0x01,0xF7,0x22 → no event, `fifo_level` stays 0. A following 0x80,0x30,0x00 → {0x80,0x30,0x00}.
- **Overflow:** with no acks, send 5 complete note-ons (DEPTH=4) → `fifo_level`=4, one `overflow` pulse, and acks return events 1–4 in order. Then ack in the same cycle as a completing byte → `fifo_level` stays 4 and no overflow.
- **Reset:** assert `rst_n`=0 after 0x90,0x3C with 2 events queued → all outputs 0 immediately. After release, a lone 0x64 produces no event.
